udp_echo_responder: RTL and testbench

- UDP responder on the application side of the UDP/IP stack.
- Consumes received datagrams from the stack's UDP output: header handshake plus byte-wide AXI-Stream payload.
- Stores each payload whole, then returns it to the sender through the stack's UDP input: swapped address/ports, same length.
- Used for link bring-up and loopback throughput tests.

---
 rtl/udp_echo_pkg.sv | 20 ++
 rtl/udp_echo_buffer.sv | 27 ++
 rtl/udp_echo_responder.sv | 217 +++++++++++++++++++++
 tb/tb_udp_echo_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_echo_pkg.sv
// Shared types and constants for the UDP echo responder.
`timescale 1ns/1ps
package udp_echo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    DROP,
    SEND_HDR,
    SEND_PAYLOAD
  } state_t;

  localparam logic [15:0] UDP_HDR_LEN = 16'd8;
  localparam logic [15:0] COUNT_MAX   = 16'hFFFF;

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == COUNT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/udp_echo_buffer.sv
// Payload store: simple dual-port RAM, DEPTH x 8, synchronous write and 1-cycle read.
`timescale 1ns/1ps
module udp_echo_buffer #(
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read data holds while rd_en is low; the top relies on this during back-pressure.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/udp_echo_responder.sv
// UDP echo responder: stores each received datagram whole, then replies to the sender.
// Optional macro UDP_ECHO_PORT_FILTER_EN: answer only on LISTEN_PORT.
`timescale 1ns/1ps
module udp_echo_responder
  import udp_echo_pkg::*;
#(
  parameter logic [15:0] LISTEN_PORT = 16'd5678,
  parameter int          DEPTH       = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_hdr_valid,
  output logic        rx_hdr_ready,
  input  logic [31:0] rx_ip_source_ip,
  input  logic [15:0] rx_source_port,
  input  logic [15:0] rx_dest_port,
  input  logic [15:0] rx_length,
  input  logic [7:0]  rx_tdata,
  input  logic        rx_tvalid,
  input  logic        rx_tlast,
  input  logic        rx_tuser,
  output logic        rx_tready,
  output logic        tx_hdr_valid,
  input  logic        tx_hdr_ready,
  output logic [31:0] tx_ip_dest_ip,
  output logic [15:0] tx_source_port,
  output logic [15:0] tx_dest_port,
  output logic [15:0] tx_length,
  output logic [7:0]  tx_tdata,
  output logic        tx_tvalid,
  output logic        tx_tlast,
  output logic        tx_tuser,
  input  logic        tx_tready,
  output logic [15:0] echo_count,
  output logic [15:0] drop_count
);

  localparam int ADDR_W = $clog2(DEPTH);

  state_t state, state_next;

  logic        run_q;
  logic [31:0] hdr_ip;
  logic [15:0] hdr_sport, hdr_dport, hdr_len;
  logic [15:0] wr_cnt, rd_cnt;
  logic        ram_valid, ram_last;
  logic [7:0]  ram_data;
  logic        out_valid, out_last;
  logic [7:0]  out_data;
  logic [15:0] echo_q, drop_q;

  logic        hdr_fire, beat_fire, txh_fire, tx_fire, final_fire;
  logic        port_ok, len_ok;
  logic [15:0] plen, wr_next;
  logic        len_match, at_full;
  logic        load, rd_issue, wr_en;
  logic        echo_inc, drop_inc;

  assign hdr_fire   = rx_hdr_valid && rx_hdr_ready;
  assign beat_fire  = rx_tvalid && rx_tready;
  assign txh_fire   = tx_hdr_valid && tx_hdr_ready;
  assign tx_fire    = tx_tvalid && tx_tready;
  assign final_fire = tx_fire && out_last;

`ifdef UDP_ECHO_PORT_FILTER_EN
  assign port_ok        = (rx_dest_port == LISTEN_PORT);
  assign tx_source_port = LISTEN_PORT;
`else
  assign port_ok        = 1'b1;
  assign tx_source_port = hdr_dport;
`endif

  // Lower bound checked first so the header subtraction below never wraps.
  assign len_ok    = (rx_length >= 16'd9) &&
                     ({16'd0, rx_length} <= (32'(DEPTH) + 32'd8));
  assign plen      = hdr_len - UDP_HDR_LEN;
  assign wr_next   = wr_cnt + 16'd1;
  assign len_match = (wr_next == plen);
  assign at_full   = ({16'd0, wr_next} == 32'(DEPTH));
  assign wr_en     = (state == CAPTURE) && beat_fire;

  // RAM output register plus one output register: a read is issued whenever the
  // RAM slot is empty or is being drained into the output register this cycle.
  assign load     = ram_valid && (!out_valid || tx_fire);
  assign rd_issue = ((state == SEND_HDR) && txh_fire) ||
                    ((state == SEND_PAYLOAD) && (rd_cnt < plen) && (!ram_valid || load));

  udp_echo_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_buffer (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_cnt[ADDR_W-1:0]),
    .wr_data (rx_tdata),
    .rd_en   (rd_issue),
    .rd_addr (rd_cnt[ADDR_W-1:0]),
    .rd_data (ram_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    rx_hdr_ready = 1'b0;
    rx_tready    = 1'b0;
    tx_hdr_valid = 1'b0;
    echo_inc     = 1'b0;
    drop_inc     = 1'b0;
    case (state)
      IDLE: begin
        rx_hdr_ready = run_q;
        if (hdr_fire) state_next = (port_ok && len_ok) ? CAPTURE : DROP;
      end
      CAPTURE: begin
        rx_tready = 1'b1;
        if (beat_fire) begin
          if (rx_tlast) begin
            if (!rx_tuser && len_match) begin
              state_next = SEND_HDR;
            end else begin
              drop_inc   = 1'b1;
              state_next = IDLE;
            end
          end else if (at_full) begin
            state_next = DROP;
          end
        end
      end
      DROP: begin
        rx_tready = 1'b1;
        if (beat_fire && rx_tlast) begin
          drop_inc   = 1'b1;
          state_next = IDLE;
        end
      end
      SEND_HDR: begin
        tx_hdr_valid = 1'b1;
        if (txh_fire) state_next = SEND_PAYLOAD;
      end
      SEND_PAYLOAD: begin
        if (final_fire) begin
          echo_inc   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q     <= 1'b0;
      hdr_ip    <= '0;
      hdr_sport <= '0;
      hdr_dport <= '0;
      hdr_len   <= '0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      ram_valid <= 1'b0;
      ram_last  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      echo_q    <= '0;
      drop_q    <= '0;
    end else begin
      run_q <= 1'b1;
      if (hdr_fire) begin
        hdr_ip    <= rx_ip_source_ip;
        hdr_sport <= rx_source_port;
        hdr_dport <= rx_dest_port;
        hdr_len   <= rx_length;
      end

      if (hdr_fire || final_fire) wr_cnt <= '0;
      else if (wr_en)             wr_cnt <= wr_next;

      if (hdr_fire || final_fire) rd_cnt <= '0;
      else if (rd_issue)          rd_cnt <= rd_cnt + 16'd1;

      if (final_fire)    ram_valid <= 1'b0;
      else if (rd_issue) ram_valid <= 1'b1;
      else if (load)     ram_valid <= 1'b0;

      if (rd_issue) ram_last <= (rd_cnt == (plen - 16'd1));

      if (final_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else if (load) begin
        out_valid <= 1'b1;
        out_data  <= ram_data;
        out_last  <= ram_last;
      end else if (tx_fire) begin
        out_valid <= 1'b0;
      end

      if (echo_inc) echo_q <= sat_inc(echo_q);
      if (drop_inc) drop_q <= sat_inc(drop_q);
    end
  end

  assign tx_ip_dest_ip = hdr_ip;
  assign tx_dest_port  = hdr_sport;
  assign tx_length     = hdr_len;
  assign tx_tdata      = out_data;
  assign tx_tvalid     = out_valid;
  assign tx_tlast      = out_last;
  assign tx_tuser      = 1'b0;
  assign echo_count    = echo_q;
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_udp_echo_responder.sv
// Randomized self-checking bench for udp_echo_responder against a datagram-level model.
`timescale 1ns/1ps
module tb_udp_echo_responder;

  localparam int          DEPTH = 16;
  localparam logic [15:0] LPORT = 16'd5678;
  localparam logic [31:0] PEER_IP = 32'hC0A80132;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_hdr_valid, rx_hdr_ready;
  logic [31:0] rx_ip_source_ip;
  logic [15:0] rx_source_port, rx_dest_port, rx_length;
  logic [7:0]  rx_tdata;
  logic        rx_tvalid, rx_tlast, rx_tuser, rx_tready;
  logic        tx_hdr_valid, tx_hdr_ready;
  logic [31:0] tx_ip_dest_ip;
  logic [15:0] tx_source_port, tx_dest_port, tx_length;
  logic [7:0]  tx_tdata;
  logic        tx_tvalid, tx_tlast, tx_tuser, tx_tready;
  logic [15:0] echo_count, drop_count;

  int checks   = 0;
  int failures = 0;
  int model_echo = 0;
  int model_drop = 0;
  logic [7:0] pay [64];

  always #5 clk = ~clk;

  udp_echo_responder #(
    .LISTEN_PORT (LPORT),
    .DEPTH       (DEPTH)
  ) dut (
    .clk (clk), .reset (reset),
    .rx_hdr_valid (rx_hdr_valid), .rx_hdr_ready (rx_hdr_ready),
    .rx_ip_source_ip (rx_ip_source_ip), .rx_source_port (rx_source_port),
    .rx_dest_port (rx_dest_port), .rx_length (rx_length),
    .rx_tdata (rx_tdata), .rx_tvalid (rx_tvalid), .rx_tlast (rx_tlast),
    .rx_tuser (rx_tuser), .rx_tready (rx_tready),
    .tx_hdr_valid (tx_hdr_valid), .tx_hdr_ready (tx_hdr_ready),
    .tx_ip_dest_ip (tx_ip_dest_ip), .tx_source_port (tx_source_port),
    .tx_dest_port (tx_dest_port), .tx_length (tx_length),
    .tx_tdata (tx_tdata), .tx_tvalid (tx_tvalid), .tx_tlast (tx_tlast),
    .tx_tuser (tx_tuser), .tx_tready (tx_tready),
    .echo_count (echo_count), .drop_count (drop_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // A datagram is echoed iff its port is served, its length fits, and the
  // stream delivered exactly length-8 good bytes.
  function automatic bit model_accepts(input logic [15:0] dp, input logic [15:0] len,
                                       input int nbeats, input bit bad);
    bit port_ok;
`ifdef UDP_ECHO_PORT_FILTER_EN
    port_ok = (dp == LPORT);
`else
    port_ok = 1'b1;
`endif
    if (!port_ok || bad) return 1'b0;
    if (int'(len) < 9 || int'(len) > DEPTH + 8) return 1'b0;
    return nbeats == int'(len) - 8;
  endfunction

  function automatic logic [15:0] model_src_port(input logic [15:0] dp);
`ifdef UDP_ECHO_PORT_FILTER_EN
    return LPORT;
`else
    return dp;
`endif
  endfunction

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
  endtask

  task automatic send_dgram(input logic [31:0] ip, input logic [15:0] sp, input logic [15:0] dp,
                            input logic [15:0] len, input int nbeats, input bit bad,
                            output int stalls);
    int budget;
    stalls = 0;
    @(negedge clk);
    rx_hdr_valid = 1'b1;
    rx_ip_source_ip = ip; rx_source_port = sp; rx_dest_port = dp; rx_length = len;
    budget = 100;
    while (!rx_hdr_ready && budget > 0) begin @(negedge clk); budget--; end
    check("rx_hdr_ready", rx_hdr_ready, 1);
    @(negedge clk);
    rx_hdr_valid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if ($urandom_range(3) == 0) begin rx_tvalid = 1'b0; @(negedge clk); end
      rx_tvalid = 1'b1;
      rx_tdata  = pay[i];
      rx_tlast  = (i == nbeats - 1);
      rx_tuser  = bad && (i == nbeats - 1);
      if (!rx_tready) stalls++;
      budget = 100;
      while (!rx_tready && budget > 0) begin @(negedge clk); budget--; end
      check("rx_tready", rx_tready, 1);
      @(negedge clk);
    end
    rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0;
  endtask

  task automatic recv_reply(input logic [31:0] ip, input logic [15:0] sp, input logic [15:0] dp,
                            input logic [15:0] len, input int mode);
    int budget, idx, n;
    logic [7:0] held;
    bit pending;
    n = int'(len) - 8;
    budget = 100;
    while (!tx_hdr_valid && budget > 0) begin @(negedge clk); budget--; end
    check("tx_hdr_valid", tx_hdr_valid, 1);
    check("tx_ip_dest_ip", tx_ip_dest_ip, ip);
    check("tx_dest_port", tx_dest_port, sp);
    check("tx_source_port", tx_source_port, model_src_port(dp));
    check("tx_length", tx_length, len);
    repeat ($urandom_range(2)) begin
      @(negedge clk);
      check("tx_hdr_hold", tx_hdr_valid, 1);
    end
    tx_hdr_ready = 1'b1;
    @(negedge clk);
    tx_hdr_ready = 1'b0;
    check("tx_hdr_clear", tx_hdr_valid, 0);
    idx = 0; budget = 400; pending = 1'b0; tx_tready = 1'b0;
    while (idx < n && budget > 0) begin
      case (mode)
        0:       tx_tready = 1'($urandom_range(1));
        1:       tx_tready = ~tx_tready;
        default: tx_tready = 1'b1;
      endcase
      if (pending) begin
        check("tx_hold_valid", tx_tvalid, 1);
        check("tx_hold_data", tx_tdata, held);
      end
      pending = 1'b0;
      if (tx_tvalid) begin
        if (tx_tready) begin
          check("tx_tdata", tx_tdata, pay[idx]);
          check("tx_tlast", tx_tlast, (idx == n - 1));
          check("tx_tuser", tx_tuser, 0);
          idx++;
        end else begin
          pending = 1'b1;
          held = tx_tdata;
        end
      end
      @(negedge clk);
      budget--;
    end
    tx_tready = 1'b0;
    check("tx_byte_count", idx, n);
    check("tx_idle_after", tx_tvalid, 0);
  endtask

  task automatic do_dgram(input logic [15:0] dp, input logic [15:0] len, input int nbeats,
                          input bit bad, input int mode);
    int stalls;
    bit expect_echo;
    logic [15:0] sp;
    sp = 16'd4000;
    expect_echo = model_accepts(dp, len, nbeats, bad);
    send_dgram(PEER_IP, sp, dp, len, nbeats, bad, stalls);
    check("rx_stalls", stalls, 0);
    if (expect_echo) begin
      recv_reply(PEER_IP, sp, dp, len, mode);
      model_echo++;
    end else begin
      repeat (4) @(negedge clk);
      check("no_tx_hdr", tx_hdr_valid, 0);
      check("no_tx_data", tx_tvalid, 0);
      model_drop++;
    end
    check("echo_count", echo_count, model_echo);
    check("drop_count", drop_count, model_drop);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls, budget, len, nb, err;
    logic [15:0] dp;
    reset = 1'b0;
    rx_hdr_valid = 0; rx_ip_source_ip = '0; rx_source_port = '0; rx_dest_port = '0;
    rx_length = '0; rx_tdata = '0; rx_tvalid = 0; rx_tlast = 0; rx_tuser = 0;
    tx_hdr_ready = 0; tx_tready = 0;
    repeat (3) @(negedge clk);
    check("rst_rx_hdr_ready", rx_hdr_ready, 0);
    check("rst_rx_tready", rx_tready, 0);
    check("rst_tx_hdr_valid", tx_hdr_valid, 0);
    check("rst_tx_tvalid", tx_tvalid, 0);
    check("rst_tx_length", tx_length, 0);
    check("rst_tx_ip", tx_ip_dest_ip, 0);
    check("rst_echo", echo_count, 0);
    check("rst_drop", drop_count, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_hdr_ready", rx_hdr_ready, 1);

    pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
    do_dgram(LPORT, 16'd12, 4, 1'b0, 2);
    do_dgram(LPORT, 16'd12, 4, 1'b1, 2);
    do_dgram(LPORT, 16'd12, 3, 1'b0, 2);
    fill_rand(4);  do_dgram(LPORT, 16'd12, 4, 1'b0, 0);
    fill_rand(32); do_dgram(LPORT, 16'd40, 32, 1'b0, 2);
    fill_rand(6);  do_dgram(16'd9999, 16'd14, 6, 1'b0, 0);
    fill_rand(16); do_dgram(LPORT, 16'd24, 16, 1'b0, 1);
    fill_rand(1);  do_dgram(LPORT, 16'd9, 1, 1'b0, 0);
    fill_rand(1);  do_dgram(LPORT, 16'd8, 1, 1'b0, 0);
    fill_rand(17); do_dgram(LPORT, 16'd25, 17, 1'b0, 0);
    fill_rand(18); do_dgram(LPORT, 16'd24, 18, 1'b0, 0);

    for (int t = 0; t < 12; t++) begin
      len = 9 + int'($urandom_range(15));
      nb  = len - 8;
      err = int'($urandom_range(3));
      if (err == 1) nb = (nb > 1) ? nb - 1 : nb + 1;
      if (err == 3) nb = nb + 1 + int'($urandom_range(3));
      dp = ($urandom_range(1) == 0) ? LPORT : 16'($urandom);
      fill_rand(nb);
      do_dgram(dp, 16'(len), nb, (err == 2), int'($urandom_range(2)));
    end

    // Reset in the middle of a reply: everything aborts, counters restart.
    fill_rand(16);
    send_dgram(PEER_IP, 16'd4000, LPORT, 16'd24, 16, 1'b0, stalls);
    budget = 100;
    while (!tx_hdr_valid && budget > 0) begin @(negedge clk); budget--; end
    check("mid_tx_hdr_valid", tx_hdr_valid, 1);
    tx_hdr_ready = 1'b1;
    @(negedge clk);
    tx_hdr_ready = 1'b0;
    tx_tready = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_tx_tvalid_pre", tx_tvalid, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_tx_tvalid", tx_tvalid, 0);
    check("mid_rst_tx_hdr_valid", tx_hdr_valid, 0);
    check("mid_rst_rx_hdr_ready", rx_hdr_ready, 0);
    check("mid_rst_rx_tready", rx_tready, 0);
    check("mid_rst_tx_tdata", tx_tdata, 0);
    check("mid_rst_echo", echo_count, 0);
    check("mid_rst_drop", drop_count, 0);
    tx_tready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_echo = 0;
    model_drop = 0;
    repeat (2) @(negedge clk);
    check("post_rst_hdr_ready", rx_hdr_ready, 1);
    check("post_rst_tx_tvalid", tx_tvalid, 0);
    fill_rand(5);
    do_dgram(LPORT, 16'd13, 5, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
